// File: rtl/es_periferico_pkg.sv
// Shared definitions for the es_periferico I/O block: register map offsets,
// timer control bit positions and interrupt line indices.
`timescale 1ns/1ps
package es_periferico_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] OFF_OUT0   = 4'd0;
  localparam logic [3:0] OFF_OUT1   = 4'd1;
  localparam logic [3:0] OFF_IN0    = 4'd2;
  localparam logic [3:0] OFF_IN1    = 4'd3;
  localparam logic [3:0] OFF_TLOAD  = 4'd4;
  localparam logic [3:0] OFF_TCTRL  = 4'd5;
  localparam logic [3:0] OFF_TCOUNT = 4'd6;
  localparam logic [3:0] OFF_PEND   = 4'd7;
  localparam logic [3:0] OFF_IMASK  = 4'd8;
  localparam logic [3:0] OFF_EMASK  = 4'd9;

  localparam int TCTRL_EN   = 0;
  localparam int TCTRL_AUTO = 1;

  localparam int IRQ_TIMER = 0;
  localparam int IRQ_EDGE  = 1;

  function automatic logic [DATA_W-1:0] pad2(input logic [1:0] v);
    return {{(DATA_W-2){1'b0}}, v};
  endfunction

endpackage

// File: rtl/es_periferico_temporizador.sv
// Prescaled down-counting timer: TLOAD reload, enable/autoreload control
// and a single-cycle fire pulse when a tick finds the count at zero.
`timescale 1ns/1ps
module temporizador
  import es_periferico_pkg::*;
#(
  parameter int PRESC = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_ctrl_we,
  input  logic [1:0]  i_ctrl_wdata,
  input  logic [15:0] i_tload,
  output logic        o_en,
  output logic        o_auto,
  output logic [15:0] o_tcount,
  output logic        o_fire
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

  logic [PW-1:0] r_presc;
  logic [15:0]   r_count;
  logic          r_en;
  logic          r_auto;
  logic          w_tick;
  logic          w_start;

  assign w_tick   = r_en && (r_presc == PRESC_LAST);
  assign o_fire   = w_tick && (r_count == 16'd0);
  assign w_start  = i_ctrl_we && i_ctrl_wdata[TCTRL_EN] && !r_en;
  assign o_en     = r_en;
  assign o_auto   = r_auto;
  assign o_tcount = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_count <= '0;
      r_en    <= 1'b0;
      r_auto  <= 1'b0;
    end else begin
      if (w_start) begin
        r_presc <= '0;
        r_count <= i_tload;
      end else if (r_en) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) begin
          if (r_count != 16'd0) r_count <= r_count - 16'd1;
          else if (r_auto)      r_count <= i_tload;
        end
      end
      // A control write overrides the one-shot self-disable on the same edge.
      if (i_ctrl_we) begin
        r_en   <= i_ctrl_wdata[TCTRL_EN];
        r_auto <= i_ctrl_wdata[TCTRL_AUTO];
      end else if (o_fire && !r_auto) begin
        r_en <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/es_periferico.sv
// Memory-mapped I/O block: output ports, synchronised inputs, timer and
// edge-detect interrupt sources driving int_e, with a tri-state read port.
`timescale 1ns/1ps
module es_periferico
  import es_periferico_pkg::*;
#(
  parameter logic [15:0] BASE  = 16'hFF00,
  parameter int          PRESC = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] direcciones,
  inout  wire  [15:0] inout_datos,
  input  logic        oe,
  input  logic        rd,
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  input  logic [7:0]  int_a,
  output logic [15:0] out0,
  output logic [15:0] out1,
  output logic [7:0]  int_e
);

  logic        w_hit, w_we, w_re;
  logic [3:0]  w_off;
  logic [15:0] w_wdata, w_rdata;
  logic [15:0] r_out0, r_out1, r_tload, r_emask;
  logic [1:0]  r_imask, r_pend;
  logic [15:0] r_in0_p0, r_in0_p1, r_in0_p2;
  logic [15:0] r_in1_p0, r_in1_p1;
  logic        w_t_en, w_t_auto, w_fire, w_edge;
  logic [15:0] w_tcount;
  logic [1:0]  w_pend_set, w_pend_clr;
  logic        w_unused_inta;

  assign w_hit   = (direcciones[15:4] == BASE[15:4]);
  assign w_off   = direcciones[3:0];
  assign w_we    = w_hit & oe;
  assign w_re    = w_hit & rd & ~oe;
  assign w_wdata = inout_datos;
  assign inout_datos = w_re ? w_rdata : 16'hzzzz;

  assign out0  = r_out0;
  assign out1  = r_out1;
  assign int_e = {6'b0, r_pend & r_imask};
  assign w_unused_inta = ^int_a[7:2];

  temporizador #(.PRESC(PRESC)) u_temporizador (
    .clk          (clk),
    .reset        (reset),
    .i_ctrl_we    (w_we && (w_off == OFF_TCTRL)),
    .i_ctrl_wdata (w_wdata[1:0]),
    .i_tload      (r_tload),
    .o_en         (w_t_en),
    .o_auto       (w_t_auto),
    .o_tcount     (w_tcount),
    .o_fire       (w_fire)
  );

  // Edge source uses the already-synchronised stages p1/p2 of in0.
  assign w_edge = |(r_in0_p1 & ~r_in0_p2 & r_emask);

  always_comb begin
    w_pend_set            = '0;
    w_pend_set[IRQ_TIMER] = w_fire;
    w_pend_set[IRQ_EDGE]  = w_edge;
    w_pend_clr            = int_a[1:0];
    if (w_we && (w_off == OFF_PEND)) w_pend_clr = w_pend_clr | w_wdata[1:0];
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_OUT0:   w_rdata = r_out0;
      OFF_OUT1:   w_rdata = r_out1;
      OFF_IN0:    w_rdata = r_in0_p1;
      OFF_IN1:    w_rdata = r_in1_p1;
      OFF_TLOAD:  w_rdata = r_tload;
      OFF_TCTRL:  w_rdata = pad2({w_t_auto, w_t_en});
      OFF_TCOUNT: w_rdata = w_tcount;
      OFF_PEND:   w_rdata = pad2(r_pend);
      OFF_IMASK:  w_rdata = pad2(r_imask);
      OFF_EMASK:  w_rdata = r_emask;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out0   <= '0;
      r_out1   <= '0;
      r_tload  <= '0;
      r_emask  <= '0;
      r_imask  <= '0;
      r_pend   <= '0;
      r_in0_p0 <= '0;
      r_in0_p1 <= '0;
      r_in0_p2 <= '0;
      r_in1_p0 <= '0;
      r_in1_p1 <= '0;
    end else begin
      // synchroniser stage p0 -> p1, edge history p2
      r_in0_p0 <= in0;
      r_in0_p1 <= r_in0_p0;
      r_in0_p2 <= r_in0_p1;
      r_in1_p0 <= in1;
      r_in1_p1 <= r_in1_p0;
      // set beats clear so a coincident event is never lost
      r_pend <= (r_pend & ~w_pend_clr) | w_pend_set;
      if (w_we) begin
        case (w_off)
          OFF_OUT0:  r_out0  <= w_wdata;
          OFF_OUT1:  r_out1  <= w_wdata;
          OFF_TLOAD: r_tload <= w_wdata;
          OFF_IMASK: r_imask <= w_wdata[1:0];
          OFF_EMASK: r_emask <= w_wdata;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_es_periferico.sv
// Randomised and directed bench for es_periferico against a behavioural
// model (pin history, arithmetic timer schedule, pending-set rules).
`timescale 1ns/1ps
module tb_es_periferico;
  import es_periferico_pkg::*;

  localparam logic [15:0] BASE  = 16'hFF00;
  localparam int          PRESC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] tb_addr = '0, tb_wdata = '0, tb_in0 = '0, tb_in1 = '0;
  logic        tb_oe = 1'b0, tb_rd = 1'b0;
  logic [7:0]  tb_inta = '0;
  wire  [15:0] bus;
  logic [15:0] out0, out1;
  logic [7:0]  int_e;

  assign bus = tb_oe ? tb_wdata : 16'hzzzz;

  es_periferico #(.BASE(BASE), .PRESC(PRESC)) dut (
    .clk(clk), .reset(reset), .direcciones(tb_addr), .inout_datos(bus),
    .oe(tb_oe), .rd(tb_rd), .in0(tb_in0), .in1(tb_in1), .int_a(tb_inta),
    .out0(out0), .out1(out1), .int_e(int_e)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_out0, m_out1, m_tload, m_emask;
  logic [1:0]  m_imask, m_pend, m_tctrl;
  logic [15:0] q_in0[$], q_in1[$];
  int          ec;
  bit          t_on, t_auto;
  int          t_e0, t_l;
  logic [15:0] t_hold;

  function automatic logic [15:0] pin0(int k);
    return (k >= 0 && k < q_in0.size()) ? q_in0[k] : 16'h0;
  endfunction
  function automatic logic [15:0] pin1(int k);
    return (k >= 0 && k < q_in1.size()) ? q_in1[k] : 16'h0;
  endfunction

  // Count after edge kk: one decrement per PRESC cycles, wrapping over L+1 ticks.
  function automatic logic [15:0] count_at(int kk);
    int t;
    if (!t_on) return t_hold;
    t = (kk - t_e0) / PRESC;
    if (t_auto) return 16'(t_l - (t % (t_l + 1)));
    return 16'(t_l - t);
  endfunction

  function automatic logic [15:0] model_read(logic [15:0] a);
    if (a[15:4] != BASE[15:4]) return 16'h0;
    case (a[3:0])
      4'd0: return m_out0;
      4'd1: return m_out1;
      4'd2: return pin0(ec - 2);
      4'd3: return pin1(ec - 2);
      4'd4: return m_tload;
      4'd5: return {14'h0, m_tctrl};
      4'd6: return count_at(ec - 1);
      4'd7: return {14'h0, m_pend};
      4'd8: return {14'h0, m_imask};
      4'd9: return m_emask;
      default: return 16'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_out0 = 0; m_out1 = 0; m_tload = 0; m_emask = 0;
    m_imask = 0; m_pend = 0; m_tctrl = 0;
    q_in0.delete(); q_in1.delete();
    ec = 0; t_on = 0; t_auto = 0; t_e0 = 0; t_l = 0; t_hold = 0;
  endtask

  task automatic model_edge();
    int k;
    bit we, fire, edg;
    logic [3:0] off;
    logic [1:0] clr;
    k   = ec;
    we  = (tb_addr[15:4] == BASE[15:4]) && tb_oe;
    off = tb_addr[3:0];
    q_in0.push_back(tb_in0);
    q_in1.push_back(tb_in1);
    fire = 0;
    if (t_on && (k - t_e0) > 0 && ((k - t_e0) % (PRESC * (t_l + 1))) == 0) begin
      fire = 1;
      if (!t_auto) begin t_on = 0; t_hold = 0; m_tctrl[0] = 1'b0; end
    end
    edg = |(pin0(k - 2) & ~pin0(k - 3) & m_emask);
    clr = tb_inta[1:0] | ((we && off == 4'd7) ? tb_wdata[1:0] : 2'b00);
    m_pend = (m_pend & ~clr) | {edg, fire};
    if (we) begin
      case (off)
        4'd0: m_out0 = tb_wdata;
        4'd1: m_out1 = tb_wdata;
        4'd4: m_tload = tb_wdata;
        4'd5: begin
          if (tb_wdata[0] && !t_on) begin
            t_on = 1; t_e0 = k; t_l = int'(m_tload); t_auto = tb_wdata[1];
          end else if (!tb_wdata[0] && t_on) begin
            t_hold = count_at(k); t_on = 0;
          end
          m_tctrl = tb_wdata[1:0];
        end
        4'd8: m_imask = tb_wdata[1:0];
        4'd9: m_emask = tb_wdata;
        default: ;
      endcase
    end
    ec++;
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    #1;
    if (tb_rd && !tb_oe && tb_addr[15:4] == BASE[15:4])
      chk($sformatf("rd_%h", tb_addr), bus, model_read(tb_addr));
    @(posedge clk);
    model_edge();
    #1;
    chk("out0", out0, m_out0);
    chk("out1", out1, m_out1);
    chk("int_e", {8'h00, int_e}, {14'h0, m_pend & m_imask});
    @(negedge clk);
    tb_oe = 0; tb_rd = 0; tb_inta = 0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    tb_addr = a; tb_wdata = d; tb_oe = 1; step();
  endtask

  task automatic rdc(input logic [15:0] a);
    tb_addr = a; tb_rd = 1; step();
  endtask

  task automatic wait_to(input int target);
    while (ec < target) rdc(BASE | 16'(OFF_TCOUNT));
  endtask

  int e0;
  int op;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    step();

    // output ports, readback, bus release
    wr(BASE | 16'h0, 16'hA5A5);
    wr(BASE | 16'h1, 16'h0F0F);
    rdc(BASE | 16'h0);
    rdc(BASE | 16'h1);
    tb_addr = BASE; #1;
    chk("bus_released", {15'h0, bus === 16'hA5A5}, 16'h0);
    step();

    // synchroniser latency and unmapped offset
    tb_in1 = 16'h1234;
    rdc(BASE | 16'h3);
    rdc(BASE | 16'h3);
    rdc(BASE | 16'h3);
    chk("in1_latency", model_read(BASE | 16'h3), 16'h1234);
    rdc(BASE | 16'hC);

    // autoreload timer, TLOAD=3 -> fires every 40 cycles
    wr(BASE | 16'h4, 16'd3);
    wr(BASE | 16'h8, 16'd1);
    wr(BASE | 16'h5, 16'd3);
    e0 = ec - 1;
    wait_to(e0 + 40);
    chk("fire_at_40_pre", {15'h0, int_e[0]}, 16'h0);
    step();
    chk("fire_at_40", {15'h0, int_e[0]}, 16'h1);
    tb_inta = 8'h01; step();
    chk("inta_clear", {15'h0, int_e[0]}, 16'h0);
    wait_to(e0 + 80);
    tb_addr = BASE | 16'h7; tb_wdata = 16'h1; tb_oe = 1; step();
    chk("w1c_vs_fire", {15'h0, int_e[0]}, 16'h1);
    wait_to(e0 + 120);
    tb_inta = 8'h01; step();
    chk("inta_vs_fire", {15'h0, int_e[0]}, 16'h1);
    wr(BASE | 16'h7, 16'h1);
    chk("w1c_clear", {15'h0, int_e[0]}, 16'h0);
    wr(BASE | 16'h5, 16'h0);
    rdc(BASE | 16'h6);

    // one-shot with TLOAD=0
    wr(BASE | 16'h4, 16'd0);
    wr(BASE | 16'h5, 16'd1);
    e0 = ec - 1;
    wait_to(e0 + 10);
    step();
    chk("oneshot_fire", {15'h0, int_e[0]}, 16'h1);
    rdc(BASE | 16'h5);
    tb_inta = 8'h01; step();
    wait_to(ec + 40);
    chk("oneshot_once", {15'h0, int_e[0]}, 16'h0);

    // edge detector
    wr(BASE | 16'h9, 16'h0001);
    wr(BASE | 16'h8, 16'h0002);
    tb_in0 = 16'h0001;
    step(); step(); step();
    chk("edge_set", {15'h0, int_e[1]}, 16'h1);
    wr(BASE | 16'h7, 16'h2);
    tb_in0 = 16'h0003;
    repeat (4) step();
    chk("edge_masked", {15'h0, int_e[1]}, 16'h0);

    // randomised traffic with the timer running
    wr(BASE | 16'h8, 16'h3);
    wr(BASE | 16'h9, 16'($urandom));
    wr(BASE | 16'h4, 16'($urandom_range(0, 4)));
    wr(BASE | 16'h5, {14'h0, 1'($urandom_range(0, 1)), 1'b1});
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) tb_in0 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) tb_in1 = 16'($urandom);
      tb_inta = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      op = $urandom_range(0, 9);
      tb_wdata = 16'($urandom);
      case (op)
        0: begin tb_addr = BASE | 16'h0; tb_oe = 1; end
        1: begin tb_addr = BASE | 16'h1; tb_oe = 1; end
        2: begin tb_addr = BASE | 16'h9; tb_oe = 1; end
        3: begin tb_addr = BASE | 16'h8; tb_oe = 1; end
        4: begin tb_addr = BASE | 16'h7; tb_oe = 1; end
        9: begin tb_addr = BASE | 16'h1; tb_oe = 1; tb_rd = 1; end
        default: begin
          tb_addr = ($urandom_range(0, 9) == 0) ? 16'h1230 : BASE;
          tb_addr[3:0] = 4'($urandom_range(0, 15));
          tb_rd = 1;
        end
      endcase
      step();
    end

    // asynchronous reset mid-run
    #2 reset = 1'b0;
    #1;
    chk("rst_out0", out0, 16'h0);
    chk("rst_out1", out1, 16'h0);
    chk("rst_int_e", {8'h00, int_e}, 16'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    rdc(BASE | 16'h6);
    rdc(BASE | 16'h5);
    rdc(BASE | 16'h7);
    repeat (30) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
